// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg                                                              |
// | Shared AHB encodings, arbiter state enum and sizing helpers.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BURST = 2'd2
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beats still to come after the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_rr_pick                                                          |
// | Round-robin pick: first request searching upward from ptr+1.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_rr_pick
    import ahb_pkg::*;
#(
    parameter int    MST_C = 2,
    localparam int   MW    = idx_w(MST_C)
) (
    input  logic [MST_C-1:0] req_i,
    input  logic [MW-1:0]    ptr_i,
    output logic [MST_C-1:0] gnt_o,
    output logic [MW-1:0]    idx_o,
    output logic             valid_o
);

    localparam int SW = MW + 1;

    logic [SW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= MST_C; k++) begin
            cand = {1'b0, ptr_i} + SW'(k);
            if (cand >= SW'(MST_C)) begin
                cand = cand - SW'(MST_C);
            end
            for (int j = 0; j < MST_C; j++) begin
                if (!valid_o && req_i[j] && (cand == SW'(j))) begin
                    gnt_o[j] = 1'b1;
                    idx_o    = MW'(j);
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_arbiter                                                          |
// | Round-robin N:1 AHB master arbiter with burst-aware handover.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int  mst_c = 2,
    localparam int MW    = idx_w(mst_c)
) (
    input  logic                        hclk,
    input  logic                        hresetn,
    input  logic [mst_c-1:0]            hbusreq_m,
    output logic [mst_c-1:0]            hgrant_m,
    input  logic [mst_c-1:0][31:0]      haddr_m,
    input  logic [mst_c-1:0][31:0]      hwdata_m,
    input  logic [mst_c-1:0][0:0]       hwrite_m,
    input  logic [mst_c-1:0][1:0]       htrans_m,
    input  logic [mst_c-1:0][2:0]       hsize_m,
    input  logic [mst_c-1:0][2:0]       hburst_m,
    output logic [31:0]                 hrdata_m,
    output logic [1:0]                  hresp_m,
    output logic                        hready_m,
    output logic [31:0]                 haddr,
    output logic [31:0]                 hwdata,
    output logic                        hwrite,
    output logic [1:0]                  htrans,
    output logic [2:0]                  hsize,
    output logic [2:0]                  hburst,
    input  logic [31:0]                 hrdata,
    input  logic [1:0]                  hresp,
    input  logic                        hready,
    output logic [MW-1:0]               hmaster
);

    arb_state_e       state_q, state_d;
    logic [mst_c-1:0] grant_q, grant_d, pick_gnt;
    logic [MW-1:0]    gidx_q, gidx_d, ptr_q, ptr_d, pick_idx;
    logic [MW-1:0]    hmaster_q, hmaster_dp_q;
    logic [3:0]       cnt_q, cnt_d, beats;
    logic             pick_valid, trans_nonseq, trans_seq, fixed_nonseq, arb_pt;

    assign haddr    = haddr_m[hmaster_q];
    assign hwrite   = hwrite_m[hmaster_q];
    assign htrans   = htrans_m[hmaster_q];
    assign hsize    = hsize_m[hmaster_q];
    assign hburst   = hburst_m[hmaster_q];
    assign hwdata   = hwdata_m[hmaster_dp_q];
    assign hrdata_m = hrdata;
    assign hresp_m  = hresp;
    assign hready_m = hready;
    assign hgrant_m = grant_q;
    assign hmaster  = hmaster_q;

    assign beats        = burst_beats(hburst);
    assign trans_nonseq = (htrans == HTRANS_NONSEQ);
    assign trans_seq    = (htrans == HTRANS_SEQ);
    assign fixed_nonseq = trans_nonseq && (beats != 4'd0);

    ahb_rr_pick #(
        .MST_C   (mst_c)
    ) u_rr_pick (
        .req_i   (hbusreq_m),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_PARK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (hready) begin
            if (cnt_d != 4'd0) begin
                state_d = ST_BURST;
            end else if (arb_pt && !pick_valid) begin
                state_d = ST_PARK;
            end else if (arb_pt || (state_q == ST_BURST)) begin
                state_d = ST_OWN;
            end
        end else if (hresp != HRESP_OKAY) begin
            // First cycle of a two-cycle response: abandon the burst.
            state_d = ST_OWN;
        end
    end

    always_comb begin
        arb_pt  = (state_q == ST_BURST) ? ((cnt_q == 4'd1) && trans_seq) : !fixed_nonseq;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        if (hready) begin
            if (trans_nonseq) begin
                cnt_d = beats;
            end else if (trans_seq && (cnt_q != 4'd0)) begin
                cnt_d = cnt_q - 4'd1;
            end
            if (arb_pt) begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    ptr_d   = pick_idx;
                end else begin
                    // Parking on master 0 does not move the round-robin pointer.
                    grant_d = mst_c'(1);
                    gidx_d  = '0;
                end
            end
        end else if (hresp != HRESP_OKAY) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            grant_q      <= mst_c'(1);
            gidx_q       <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            hmaster_q    <= '0;
            hmaster_dp_q <= '0;
        end else begin
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (hready) begin
                hmaster_q    <= gidx_q;
                hmaster_dp_q <= hmaster_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_arbiter                                                       |
// | Vector table, corner sequences and random run against a model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ahb_arbiter;
    import ahb_pkg::*;

    localparam int N  = 3;
    localparam int MW = 2;

    logic                 hclk = 1'b0;
    logic                 hresetn;
    logic [N-1:0]         hbusreq_m;
    logic [N-1:0]         hgrant_m;
    logic [N-1:0][31:0]   haddr_m;
    logic [N-1:0][31:0]   hwdata_m;
    logic [N-1:0][0:0]    hwrite_m;
    logic [N-1:0][1:0]    htrans_m;
    logic [N-1:0][2:0]    hsize_m;
    logic [N-1:0][2:0]    hburst_m;
    logic [31:0]          hrdata_m;
    logic [1:0]           hresp_m;
    logic                 hready_m;
    logic [31:0]          haddr;
    logic [31:0]          hwdata;
    logic                 hwrite;
    logic [1:0]           htrans;
    logic [2:0]           hsize;
    logic [2:0]           hburst;
    logic [31:0]          hrdata;
    logic [1:0]           hresp;
    logic                 hready;
    logic [MW-1:0]        hmaster;

    ahb_arbiter #(.mst_c(N)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq_m (hbusreq_m),
        .hgrant_m  (hgrant_m),
        .haddr_m   (haddr_m),
        .hwdata_m  (hwdata_m),
        .hwrite_m  (hwrite_m),
        .htrans_m  (htrans_m),
        .hsize_m   (hsize_m),
        .hburst_m  (hburst_m),
        .hrdata_m  (hrdata_m),
        .hresp_m   (hresp_m),
        .hready_m  (hready_m),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hsize     (hsize),
        .hburst    (hburst),
        .hrdata    (hrdata),
        .hresp     (hresp),
        .hready    (hready),
        .hmaster   (hmaster)
    );

    always #5 hclk = ~hclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [1:0]    trans;
        logic [2:0]    burst;
        logic          rdy;
        logic [1:0]    resp;
        logic [N-1:0]  g;
        logic [MW-1:0] m;
        logic [MW-1:0] dm;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [N-1:0] req, input logic [1:0] trans, input logic [2:0] burst,
                       input logic rdy, input logic [1:0] resp,
                       input logic [N-1:0] g, input logic [MW-1:0] m, input logic [MW-1:0] dm);
        vec_t v;
        v.req = req; v.trans = trans; v.burst = burst; v.rdy = rdy; v.resp = resp;
        v.g = g; v.m = m; v.dm = dm;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [1:0] trans, input logic [2:0] burst,
                         input logic rdy, input logic [1:0] resp);
        hbusreq_m = req;
        for (int j = 0; j < N; j++) begin
            htrans_m[j] = trans;
            hburst_m[j] = burst;
        end
        hready = rdy;
        hresp  = resp;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
    endtask

    // Reference model: owner indices and beats remaining, as integers.
    int m_grant, m_owner, m_down, m_left, m_last;

    task automatic model_reset();
        m_grant = 0; m_owner = 0; m_down = 0; m_left = 0; m_last = 0;
    endtask

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_step();
        int  t, len, nl, ng, idx;
        bit  arb, found;
        if (!hready) begin
            if (hresp != 2'b00) m_left = 0;
        end else begin
            t   = int'(htrans_m[m_owner]);
            len = burst_len(hburst_m[m_owner]);
            arb = (m_left == 0 && !(t == 2 && len > 1)) || (m_left == 1 && t == 3);
            if (t == 2)      nl = len - 1;
            else if (t == 3) nl = (m_left > 0) ? m_left - 1 : 0;
            else             nl = m_left;
            ng = m_grant;
            if (arb) begin
                found = 1'b0;
                ng    = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && hbusreq_m[idx]) begin
                        found = 1'b1;
                        ng    = idx;
                    end
                end
                if (found) m_last = ng;
            end
            m_down  = m_owner;
            m_owner = m_grant;
            m_grant = ng;
            m_left  = nl;
        end
    endtask

    function automatic logic [1:0] rand_trans();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return HTRANS_IDLE;
        if (r == 1) return HTRANS_BUSY;
        if (r <= 4) return HTRANS_NONSEQ;
        return HTRANS_SEQ;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b0;
        for (int j = 0; j < N; j++) begin
            haddr_m[j]  = 32'h100 * j;
            hwdata_m[j] = 32'hDA7A_0000 + j;
            hwrite_m[j] = 1'(j);
            hsize_m[j]  = 3'd2;
        end
        hrdata = 32'h1234_5678;
        drive(3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
        do_reset();

        check("reset hgrant_m", 32'(hgrant_m), 32'b001);
        check("reset hmaster", 32'(hmaster), 32'd0);
        check("reset htrans", 32'(htrans), 32'(HTRANS_IDLE));
        check("reset hwdata", hwdata, hwdata_m[0]);

        // req, trans, burst, rdy, resp -> grant, hmaster, data-phase owner
        add(3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b001, 0, 0);
        add(3'b011, HTRANS_NONSEQ, HBURST_SINGLE, 1, HRESP_OKAY,  3'b010, 0, 0);
        add(3'b011, HTRANS_NONSEQ, HBURST_SINGLE, 1, HRESP_OKAY,  3'b001, 1, 0);
        add(3'b011, HTRANS_NONSEQ, HBURST_SINGLE, 1, HRESP_OKAY,  3'b010, 0, 1);
        add(3'b011, HTRANS_NONSEQ, HBURST_SINGLE, 1, HRESP_OKAY,  3'b001, 1, 0);
        add(3'b010, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b010, 0, 1);
        add(3'b010, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b010, 1, 0);
        add(3'b010, HTRANS_NONSEQ, HBURST_INCR4,  1, HRESP_OKAY,  3'b010, 1, 1);
        add(3'b011, HTRANS_SEQ,    HBURST_INCR4,  1, HRESP_OKAY,  3'b010, 1, 1);
        add(3'b011, HTRANS_SEQ,    HBURST_INCR4,  1, HRESP_OKAY,  3'b010, 1, 1);
        add(3'b011, HTRANS_SEQ,    HBURST_INCR4,  1, HRESP_OKAY,  3'b001, 1, 1);
        add(3'b011, HTRANS_IDLE,   HBURST_SINGLE, 0, HRESP_OKAY,  3'b001, 1, 1);
        add(3'b011, HTRANS_IDLE,   HBURST_SINGLE, 0, HRESP_OKAY,  3'b001, 1, 1);
        add(3'b011, HTRANS_IDLE,   HBURST_SINGLE, 0, HRESP_OKAY,  3'b001, 1, 1);
        add(3'b011, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b010, 0, 1);
        add(3'b010, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b010, 1, 0);
        add(3'b010, HTRANS_NONSEQ, HBURST_INCR8,  1, HRESP_OKAY,  3'b010, 1, 1);
        add(3'b011, HTRANS_SEQ,    HBURST_INCR8,  1, HRESP_OKAY,  3'b010, 1, 1);
        add(3'b011, HTRANS_SEQ,    HBURST_INCR8,  0, HRESP_ERROR, 3'b010, 1, 1);
        add(3'b011, HTRANS_IDLE,   HBURST_INCR8,  0, HRESP_ERROR, 3'b010, 1, 1);
        add(3'b011, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b001, 1, 1);
        add(3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b001, 0, 1);
        add(3'b100, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b100, 0, 0);
        add(3'b001, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b001, 2, 0);
        add(3'b000, HTRANS_IDLE,   HBURST_SINGLE, 1, HRESP_OKAY,  3'b001, 0, 2);

        foreach (vq[i]) begin
            drive(vq[i].req, vq[i].trans, vq[i].burst, vq[i].rdy, vq[i].resp);
            @(posedge hclk); #1;
            check($sformatf("vec%0d hgrant_m", i), 32'(hgrant_m), 32'(vq[i].g));
            check($sformatf("vec%0d hmaster", i), 32'(hmaster), 32'(vq[i].m));
            check($sformatf("vec%0d hwdata", i), hwdata, hwdata_m[vq[i].dm]);
            check($sformatf("vec%0d haddr", i), haddr, haddr_m[vq[i].m]);
        end

        // Master 2 runs an INCR16 while master 0 also requests; reset lands mid-burst.
        drive(3'b100, HTRANS_IDLE, HBURST_SINGLE, 1, HRESP_OKAY);
        repeat (2) @(posedge hclk);
        #1 drive(3'b101, HTRANS_NONSEQ, HBURST_INCR16, 1, HRESP_OKAY);
        @(posedge hclk); #1;
        drive(3'b101, HTRANS_SEQ, HBURST_INCR16, 1, HRESP_OKAY);
        repeat (2) @(posedge hclk);
        #1;
        check("incr16 hgrant_m held", 32'(hgrant_m), 32'b100);
        check("incr16 hmaster", 32'(hmaster), 32'd2);
        #2 hresetn = 1'b0;
        #1;
        check("async rst hgrant_m", 32'(hgrant_m), 32'b001);
        check("async rst hmaster", 32'(hmaster), 32'd0);
        check("async rst haddr", haddr, haddr_m[0]);
        check("async rst hwdata", hwdata, hwdata_m[0]);
        @(posedge hclk);
        #1 hresetn = 1'b1;
        drive(3'b011, HTRANS_SEQ, HBURST_INCR16, 1, HRESP_OKAY);
        @(posedge hclk); #1;
        check("post rst arbitration", 32'(hgrant_m), 32'b010);

        // Randomised traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            hbusreq_m = N'($urandom_range(0, (1 << N) - 1));
            for (int j = 0; j < N; j++) begin
                haddr_m[j]  = $urandom;
                hwdata_m[j] = $urandom;
                hwrite_m[j] = 1'($urandom);
                htrans_m[j] = rand_trans();
                hsize_m[j]  = 3'($urandom);
                hburst_m[j] = 3'($urandom);
            end
            hrdata = $urandom;
            hready = ($urandom_range(0, 3) != 0);
            hresp  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            #1;
            check("rnd haddr", haddr, haddr_m[m_owner]);
            check("rnd htrans", 32'(htrans), 32'(htrans_m[m_owner]));
            check("rnd hburst", 32'(hburst), 32'(hburst_m[m_owner]));
            check("rnd hsize", 32'(hsize), 32'(hsize_m[m_owner]));
            check("rnd hwrite", 32'(hwrite), 32'(hwrite_m[m_owner]));
            check("rnd hwdata", hwdata, hwdata_m[m_down]);
            check("rnd hrdata_m", hrdata_m, hrdata);
            check("rnd hresp_m", 32'(hresp_m), 32'(hresp));
            check("rnd hready_m", 32'(hready_m), 32'(hready));
            model_step();
            @(posedge hclk); #1;
            check("rnd hgrant_m", 32'(hgrant_m), 32'(1) << m_grant);
            check("rnd hmaster", 32'(hmaster), 32'(m_owner));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
